// File: rtl/rx_packet_queue.sv
// rx_packet_queue: store-and-forward receive queue between the MAC RX datapath
// and the input arbiter. Whole frames are buffered, then released on an
// AXI-Stream master. Bad, malformed and overflowing frames are discarded by
// rewinding the write pointer to the last committed frame boundary.
//
// Ports
//   clk, reset_n                 core clock, asynchronous active-low reset
//   mac_tdata/tkeep/tvalid/tlast/tuser   MAC receive beat (no backpressure)
//   m_axis_tdata/tstrb/tuser/tvalid/tlast, m_axis_tready   stream master;
//                                tuser carries the frame byte length on beat 0
//   drop_pulse                   one-cycle pulse per discarded frame
//   drop_cnt                     frames dropped for no space / oversize (saturating)
//   bad_cnt                      frames dropped for mac_tuser or bad tkeep (saturating)
//
// Write FSM
//   state | meaning
//   SYNC  | after reset: discard a frame possibly already in progress
//   IDLE  | between frames, waiting for a first beat
//   WRITE | storing an admitted frame
//   DROP  | discarding the rest of a rejected frame
module rx_packet_queue #(
  parameter int DATA_WIDTH    = 64,
  parameter int DEPTH_LOG2    = 10,
  parameter int MAX_PKT_BEATS = 1200,
  parameter int LEN_FIFO_LOG2 = 5,
  parameter int CNT_WIDTH     = 32
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [DATA_WIDTH-1:0]   mac_tdata,
  input  logic [DATA_WIDTH/8-1:0] mac_tkeep,
  input  logic                    mac_tvalid,
  input  logic                    mac_tlast,
  input  logic                    mac_tuser,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m_axis_tstrb,
  output logic [15:0]             m_axis_tuser,
  output logic                    m_axis_tvalid,
  output logic                    m_axis_tlast,
  input  logic                    m_axis_tready,
  output logic                    drop_pulse,
  output logic [CNT_WIDTH-1:0]    drop_cnt,
  output logic [CNT_WIDTH-1:0]    bad_cnt
);
  localparam int KW  = DATA_WIDTH / 8;
  localparam int PW  = DEPTH_LOG2 + 1;
  localparam int PW1 = PW + 1;
  localparam int LW  = LEN_FIFO_LOG2 + 1;
  localparam logic [PW:0]   BUF_DEPTH = PW1'(2**DEPTH_LOG2);
  localparam logic [PW:0]   MAX_BEATS = PW1'(MAX_PKT_BEATS);
  localparam logic [LW-1:0] LF_DEPTH  = LW'(2**LEN_FIFO_LOG2);
  localparam logic [15:0]   BPB       = 16'(KW);

  typedef enum logic [1:0] {SYNC, IDLE, WRITE, DROP} wr_state_t;

  function automatic logic [15:0] popcount(input logic [KW-1:0] k);
    logic [15:0] n;
    n = '0;
    for (int i = 0; i < KW; i++) n = n + 16'(k[i]);
    return n;
  endfunction

  logic [DATA_WIDTH-1:0] data_mem [2**DEPTH_LOG2];
  logic [KW-1:0]         keep_mem [2**DEPTH_LOG2];
  logic [15:0]           len_mem  [2**LEN_FIFO_LOG2];

  wr_state_t wr_state, wr_nxt;
  logic [PW-1:0] wr_ptr, commit_ptr, rd_ptr, used;
  logic [PW:0]   free_beats;
  logic [PW-1:0] beat_cnt, beat_nxt;
  logic [15:0]   byte_cnt, byte_nxt, beat_bytes;
  logic [LW-1:0] lf_wr, lf_pop;
  logic [LEN_FIFO_LOG2-1:0] lf_rd;
  logic lf_full, admit;
  logic wr_en, adv, rewind, commit, drop_ev, bad_ev;

  // Free space is judged against the worst-case frame so an admitted frame can never overrun.
  assign used       = wr_ptr - rd_ptr;
  assign free_beats = BUF_DEPTH - {1'b0, used};
  assign lf_full    = (lf_wr - lf_pop) == LF_DEPTH;
  assign admit      = (free_beats >= MAX_BEATS) && !lf_full;
  assign beat_bytes = popcount(mac_tkeep);

  always_comb begin
    wr_nxt   = wr_state;
    wr_en    = 1'b0;
    adv      = 1'b0;
    rewind   = 1'b0;
    commit   = 1'b0;
    drop_ev  = 1'b0;
    bad_ev   = 1'b0;
    byte_nxt = byte_cnt;
    beat_nxt = beat_cnt;
    case (wr_state)
      SYNC: if (!mac_tvalid || mac_tlast) wr_nxt = IDLE;
      IDLE: if (mac_tvalid) begin
        if (admit) begin
          wr_en    = 1'b1;
          byte_nxt = beat_bytes;
          beat_nxt = PW'(1);
          if (mac_tlast) begin
            // Single-beat frame: wr_ptr has not moved, so a bad one needs no rewind.
            if (mac_tuser) bad_ev = 1'b1;
            else           commit = 1'b1;
          end else begin
            adv    = 1'b1;
            wr_nxt = WRITE;
          end
        end else begin
          drop_ev = 1'b1;
          if (!mac_tlast) wr_nxt = DROP;
        end
      end
      WRITE: if (mac_tvalid) begin
        wr_en    = 1'b1;
        byte_nxt = byte_cnt + beat_bytes;
        beat_nxt = beat_cnt + 1'b1;
        if (mac_tlast) begin
          wr_nxt = IDLE;
          if (mac_tuser) begin
            rewind = 1'b1;
            bad_ev = 1'b1;
          end else begin
            commit = 1'b1;
          end
        end else if (mac_tkeep != '1) begin
          rewind = 1'b1;
          bad_ev = 1'b1;
          wr_nxt = DROP;
        end else if (beat_nxt == PW'(MAX_PKT_BEATS)) begin
          // The longest legal frame would have ended on this beat.
          rewind  = 1'b1;
          drop_ev = 1'b1;
          wr_nxt  = DROP;
        end else begin
          adv = 1'b1;
        end
      end
      DROP: if (mac_tvalid && mac_tlast) wr_nxt = IDLE;
      default: wr_nxt = SYNC;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_state   <= SYNC;
      wr_ptr     <= '0;
      commit_ptr <= '0;
      byte_cnt   <= '0;
      beat_cnt   <= '0;
      lf_wr      <= '0;
      drop_cnt   <= '0;
      bad_cnt    <= '0;
      drop_pulse <= 1'b0;
    end else begin
      wr_state <= wr_nxt;
      byte_cnt <= byte_nxt;
      beat_cnt <= beat_nxt;
      if (commit) begin
        wr_ptr     <= wr_ptr + 1'b1;
        commit_ptr <= wr_ptr + 1'b1;
        lf_wr      <= lf_wr + 1'b1;
      end else if (rewind) begin
        wr_ptr <= commit_ptr;
      end else if (adv) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (drop_ev && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
      if (bad_ev && bad_cnt != '1)   bad_cnt  <= bad_cnt + 1'b1;
      drop_pulse <= drop_ev | bad_ev;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      data_mem[wr_ptr[DEPTH_LOG2-1:0]] <= mac_tdata;
      keep_mem[wr_ptr[DEPTH_LOG2-1:0]] <= mac_tkeep;
    end
    if (commit) len_mem[lf_wr[LEN_FIFO_LOG2-1:0]] <= byte_nxt;
  end

  // Read side: the output register doubles as the registered RAM read, loaded
  // whenever it is empty or being consumed, giving 1 beat/cycle and a two-cycle
  // commit-to-tvalid latency. Frame boundaries are tracked by the remaining byte
  // count; lf_rd peeks the length at load, lf_pop frees it at the first handshake.
  logic        rd_first, m_first, load;
  logic [15:0] rem, cur_len;

  assign load    = (rd_ptr != commit_ptr) && (!m_axis_tvalid || m_axis_tready);
  assign cur_len = rd_first ? len_mem[lf_rd] : rem;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr        <= '0;
      lf_rd         <= '0;
      lf_pop        <= '0;
      rd_first      <= 1'b1;
      rem           <= '0;
      m_first       <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tstrb  <= '0;
      m_axis_tuser  <= '0;
      m_axis_tlast  <= 1'b0;
    end else begin
      if (m_axis_tvalid && m_axis_tready && m_first) lf_pop <= lf_pop + 1'b1;
      if (load) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= data_mem[rd_ptr[DEPTH_LOG2-1:0]];
        m_axis_tstrb  <= keep_mem[rd_ptr[DEPTH_LOG2-1:0]];
        m_axis_tuser  <= rd_first ? cur_len : 16'h0;
        m_axis_tlast  <= (cur_len <= BPB);
        m_first       <= rd_first;
        rd_ptr        <= rd_ptr + 1'b1;
        if (rd_first) lf_rd <= lf_rd + 1'b1;
        if (cur_len <= BPB) begin
          rd_first <= 1'b1;
        end else begin
          rd_first <= 1'b0;
          rem      <= cur_len - BPB;
        end
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_rx_packet_queue.sv
module tb_rx_packet_queue;
  logic        clk, reset_n;
  logic [63:0] mac_tdata;
  logic [7:0]  mac_tkeep;
  logic        mac_tvalid, mac_tlast, mac_tuser;
  logic [63:0] m_axis_tdata;
  logic [7:0]  m_axis_tstrb;
  logic [15:0] m_axis_tuser;
  logic        m_axis_tvalid, m_axis_tlast, m_axis_tready;
  logic        drop_pulse;
  logic [31:0] drop_cnt, bad_cnt;

  rx_packet_queue #(.DATA_WIDTH(64), .DEPTH_LOG2(11), .MAX_PKT_BEATS(1200),
                    .LEN_FIFO_LOG2(5), .CNT_WIDTH(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .mac_tdata(mac_tdata), .mac_tkeep(mac_tkeep), .mac_tvalid(mac_tvalid),
    .mac_tlast(mac_tlast), .mac_tuser(mac_tuser),
    .m_axis_tdata(m_axis_tdata), .m_axis_tstrb(m_axis_tstrb), .m_axis_tuser(m_axis_tuser),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
    .drop_pulse(drop_pulse), .drop_cnt(drop_cnt), .bad_cnt(bad_cnt));

  typedef struct {
    logic [63:0] data;
    logic [7:0]  strb;
    logic [15:0] user;
    logic        last;
  } beat_t;

  typedef struct {
    int nbytes;
    bit bad;
    bit malf;
    bit out;
    int bad_inc;
    int drop_inc;
  } vec_t;

  beat_t exp_q[$];
  int total = 0, bad = 0;
  int cyc = 0, tlast_cyc = 0, fid = 1;
  int exp_bad = 0, exp_drop = 0, exp_pulse = 0, pulse_seen = 0;
  bit rand_rdy = 0, rdy_fix = 1, rnd_bit = 1;

  assign m_axis_tready = rand_rdy ? rnd_bit : rdy_fix;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    rnd_bit = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #3ms;
    $display("FAIL global_timeout cyc=%0d required finish", cyc);
    $fatal(1);
  end

  // Scoreboard and AXI hold checks, sampled mid-cycle.
  beat_t prev;
  bit prev_stall = 0;
  always @(negedge clk) begin
    beat_t e;
    if (!reset_n) begin
      prev_stall = 0;
    end else begin
      if (drop_pulse) pulse_seen++;
      if (prev_stall) begin
        total++;
        if (!m_axis_tvalid || m_axis_tdata !== prev.data || m_axis_tstrb !== prev.strb ||
            m_axis_tuser !== prev.user || m_axis_tlast !== prev.last) begin
          bad++;
          $display("FAIL axi_hold got v=%b data=%h required v=1 data=%h", m_axis_tvalid,
                   m_axis_tdata, prev.data);
        end
      end
      prev.data = m_axis_tdata; prev.strb = m_axis_tstrb;
      prev.user = m_axis_tuser; prev.last = m_axis_tlast;
      prev_stall = m_axis_tvalid && !m_axis_tready;
      if (m_axis_tvalid && m_axis_tready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_beat got data=%h user=%0d required no beat", m_axis_tdata,
                   m_axis_tuser);
        end else begin
          e = exp_q.pop_front();
          if (m_axis_tdata !== e.data || m_axis_tstrb !== e.strb ||
              m_axis_tuser !== e.user || m_axis_tlast !== e.last) begin
            bad++;
            $display("FAIL beat got data=%h strb=%h user=%0d last=%b required data=%h strb=%h user=%0d last=%b",
                     m_axis_tdata, m_axis_tstrb, m_axis_tuser, m_axis_tlast,
                     e.data, e.strb, e.user, e.last);
          end
        end
      end
    end
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  task automatic send_frame(input int nbytes, input bit bad_f, input bit malf, input bit exp_out);
    int nb, rem;
    logic [7:0] kp;
    beat_t e;
    nb = (nbytes + 7) / 8;
    for (int b = 0; b < nb; b++) begin
      rem = nbytes - 8 * b;
      kp = (rem >= 8) ? 8'hFF : 8'((1 << rem) - 1);
      if (malf && b == 1) kp = 8'h0F;
      @(posedge clk); #1;
      mac_tvalid = 1;
      mac_tdata  = {16'(fid), 16'(b), 32'(fid * 131 + b)};
      mac_tkeep  = kp;
      mac_tlast  = (b == nb - 1);
      mac_tuser  = bad_f && (b == nb - 1);
      if (b == nb - 1) tlast_cyc = cyc;
      if (exp_out) begin
        e.data = mac_tdata;
        e.strb = kp;
        e.user = (b == 0) ? 16'(nbytes) : 16'h0;
        e.last = (b == nb - 1);
        exp_q.push_back(e);
      end
    end
    @(posedge clk); #1;
    mac_tvalid = 0; mac_tlast = 0; mac_tuser = 0;
    fid++;
  endtask

  task automatic wait_drain(input string nm);
    int n;
    n = 0;
    repeat (6) @(negedge clk);
    while ((exp_q.size() != 0 || m_axis_tvalid) && n < 4000) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n >= 4000) begin
      bad++;
      $display("FAIL %s drain_timeout left=%0d required=0", nm, exp_q.size());
    end
  endtask

  task automatic check_stats(input string nm);
    check({nm, "_drop_cnt"}, drop_cnt, exp_drop);
    check({nm, "_bad_cnt"}, bad_cnt, exp_bad);
    check({nm, "_pulses"}, pulse_seen, exp_pulse);
  endtask

  vec_t vecs[10];
  int n;

  initial begin
    vecs[0] = '{61,  0, 0, 1, 0, 0};
    vecs[1] = '{64,  1, 0, 0, 1, 0};
    vecs[2] = '{8,   0, 0, 1, 0, 0};
    vecs[3] = '{1,   0, 0, 1, 0, 0};
    vecs[4] = '{200, 0, 0, 1, 0, 0};
    vecs[5] = '{40,  0, 1, 0, 1, 0};
    vecs[6] = '{16,  1, 0, 0, 1, 0};
    vecs[7] = '{120, 0, 0, 1, 0, 0};
    vecs[8] = '{9,   0, 0, 1, 0, 0};
    vecs[9] = '{8,   1, 0, 0, 1, 0};

    reset_n = 0; mac_tvalid = 0; mac_tlast = 0; mac_tuser = 0;
    mac_tdata = '0; mac_tkeep = '0;
    repeat (3) @(negedge clk);
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_outs", {m_axis_tdata[31:0], m_axis_tstrb, m_axis_tuser, m_axis_tlast}, 0);
    check("rst_cnts", {drop_cnt, bad_cnt} | 64'(drop_pulse), 0);
    @(posedge clk); #1;
    reset_n = 1;
    repeat (2) @(posedge clk);

    // 64B frame: latency and first-beat length
    send_frame(64, 0, 0, 1);
    n = 0;
    while (!m_axis_tvalid && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("first_tvalid_latency", cyc - tlast_cyc, 2);
    wait_drain("t1");
    check_stats("t1");

    // table of single frames under random backpressure
    rand_rdy = 1;
    foreach (vecs[i]) begin
      send_frame(vecs[i].nbytes, vecs[i].bad, vecs[i].malf, vecs[i].out);
      exp_bad   += vecs[i].bad_inc;
      exp_drop  += vecs[i].drop_inc;
      exp_pulse += vecs[i].bad_inc + vecs[i].drop_inc;
      wait_drain("vec");
      check_stats($sformatf("vec%0d", i));
    end
    rand_rdy = 0;

    // 20 frames held with tready low, then a contiguous release
    rdy_fix = 0;
    repeat (20) send_frame(64, 0, 0, 1);
    repeat (5) @(posedge clk);
    #1 rdy_fix = 1;
    n = 0;
    for (int i = 0; i < 160; i++) begin
      @(negedge clk);
      if (m_axis_tvalid) n++;
    end
    check("burst_contiguous", n, 160);
    wait_drain("t3");

    // length FIFO full: 33rd frame dropped
    rdy_fix = 0;
    repeat (32) send_frame(8, 0, 0, 1);
    send_frame(8, 0, 0, 0);
    exp_drop++; exp_pulse++;
    rdy_fix = 1;
    wait_drain("lf_full");
    check_stats("lf_full");
    send_frame(8, 0, 0, 1);
    wait_drain("lf_after");

    // buffer space below one maximal frame
    rdy_fix = 0;
    repeat (4) send_frame(1760, 0, 0, 1);
    send_frame(64, 0, 0, 0);
    exp_drop++; exp_pulse++;
    repeat (4) @(posedge clk);
    #1 rdy_fix = 1;
    wait_drain("nospace");
    check_stats("nospace");
    send_frame(64, 0, 0, 1);
    wait_drain("resend");

    // oversize frame
    send_frame(1201 * 8, 0, 0, 0);
    exp_drop++; exp_pulse++;
    send_frame(64, 0, 0, 1);
    wait_drain("oversize");
    check_stats("oversize");

    // exactly the longest legal frame
    send_frame(1200 * 8, 0, 0, 1);
    wait_drain("maxlen");
    check_stats("maxlen");

    // reset in the middle of a frame with 3 frames buffered
    rdy_fix = 0;
    repeat (3) send_frame(64, 0, 0, 1);
    for (int b = 0; b < 3; b++) begin
      @(posedge clk); #1;
      mac_tvalid = 1; mac_tdata = 64'hDEAD_0000 + 64'(b); mac_tkeep = 8'hFF;
      mac_tlast = 0; mac_tuser = 0;
    end
    @(posedge clk); #1;
    reset_n = 0;
    mac_tdata = 64'hDEAD_0003;
    exp_q.delete();
    exp_bad = 0; exp_drop = 0; exp_pulse = 0; pulse_seen = 0;
    @(negedge clk);
    check("midrst_tvalid", m_axis_tvalid, 0);
    check("midrst_outs", {m_axis_tdata[31:0], m_axis_tstrb, m_axis_tuser, m_axis_tlast}, 0);
    check("midrst_cnts", {drop_cnt, bad_cnt} | 64'(drop_pulse), 0);
    @(posedge clk); #1;
    reset_n = 1;
    mac_tdata = 64'hDEAD_0004;
    @(posedge clk); #1;
    mac_tdata = 64'hDEAD_0005;
    @(posedge clk); #1;
    mac_tdata = 64'hDEAD_0006; mac_tlast = 1;
    @(posedge clk); #1;
    mac_tvalid = 0; mac_tlast = 0;
    rdy_fix = 1;
    repeat (5) @(posedge clk);
    send_frame(64, 0, 0, 1);
    wait_drain("after_reset");
    check_stats("after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
